// File: rtl/choreo_pkg.sv
// Shared constants, pattern codes and small helpers for the LED choreography blocks.
package choreo_pkg;

    localparam int unsigned PAT_W = 3;
    typedef logic [PAT_W-1:0] pat_t;

    localparam pat_t PAT_KNIGHT  = pat_t'(0);
    localparam pat_t PAT_WALK    = pat_t'(1);
    localparam pat_t PAT_EXPAND  = pat_t'(2);
    localparam pat_t PAT_BLINK   = pat_t'(3);
    localparam pat_t PAT_ALT     = pat_t'(4);
    localparam pat_t PAT_MARQUEE = pat_t'(5);
    localparam pat_t PAT_SPARKLE = pat_t'(6);
    localparam pat_t PAT_OFF     = pat_t'(7);

    localparam int unsigned DEBOUNCE_DEFAULT = 4;
    localparam int unsigned NUM_BTN          = 5;

    typedef enum logic [2:0] {
        BtnNext,
        BtnPrev,
        BtnPause,
        BtnSpeed,
        BtnAuto
    } btn_idx_e;

    function automatic pat_t pat_inc(pat_t p, int unsigned num);
        return (32'(p) + 32'd1 >= num) ? '0 : p + pat_t'(1);
    endfunction

    function automatic pat_t pat_dec(pat_t p, int unsigned num);
        return (p == '0) ? pat_t'(num - 1) : p - pat_t'(1);
    endfunction

endpackage

// File: rtl/led_ctrl_frontend_if.sv
// Button inputs and generator control outputs of the LED front-end.
interface led_ctrl_frontend_if;
    import choreo_pkg::*;

    logic       ena;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_pause;
    logic       btn_speed;
    logic       btn_auto;
    pat_t       pat_sel;
    logic       speed_sel;
    logic       pause;
    logic       auto_mode;
    logic       pat_change;

    modport master (
        output ena, btn_next, btn_prev, btn_pause, btn_speed, btn_auto,
        input  pat_sel, speed_sel, pause, auto_mode, pat_change
    );

    modport slave (
        input  ena, btn_next, btn_prev, btn_pause, btn_speed, btn_auto,
        output pat_sel, speed_sel, pause, auto_mode, pat_change
    );

endinterface

// File: rtl/led_ctrl_frontend_btn_debounce.sv
// One push-button path: 2-flop synchronizer, debounce counter, stable level, press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/led_ctrl_frontend.sv
// Button front-end for the LED pattern generator: debounced commands plus auto-cycle mode.
module led_ctrl_frontend
    import choreo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_DEFAULT,
    parameter int unsigned AUTO_CYCLE_TICKS = 16,
    parameter int unsigned NUM_PATTERNS     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_ctrl_frontend_if.slave    bus
);

    localparam int unsigned CntW = $clog2(AUTO_CYCLE_TICKS);

    logic [NUM_BTN-1:0] btn_raw, btn_press, unused_stable;

    assign btn_raw = {bus.btn_auto, bus.btn_speed, bus.btn_pause, bus.btn_prev, bus.btn_next};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_raw[gi]),
            .stable_o (unused_stable[gi]),
            .press_o  (btn_press[gi])
        );
    end

    pat_t            pat_q, pat_d;
    logic            speed_q, speed_d;
    logic            pause_q, pause_d;
    logic            auto_q, auto_d;
    logic            chg_q, chg_d;
    logic [CntW-1:0] acnt_q, acnt_d;

    logic net_next, net_prev, auto_run, auto_term;

    assign net_next  = bus.ena & btn_press[BtnNext] & ~btn_press[BtnPrev];
    assign net_prev  = bus.ena & btn_press[BtnPrev] & ~btn_press[BtnNext];
    assign auto_run  = auto_q & ~pause_q & bus.ena;
    assign auto_term = (acnt_q == CntW'(AUTO_CYCLE_TICKS - 1));

    always_comb begin
        pat_d   = pat_q;
        speed_d = speed_q;
        pause_d = pause_q;
        auto_d  = auto_q;
        acnt_d  = acnt_q;
        // A manual step wins over a coinciding auto step and restarts the period.
        if (net_next) begin
            pat_d  = pat_inc(pat_q, NUM_PATTERNS);
            acnt_d = '0;
        end else if (net_prev) begin
            pat_d  = pat_dec(pat_q, NUM_PATTERNS);
            acnt_d = '0;
        end else if (auto_run) begin
            if (auto_term) begin
                pat_d  = pat_inc(pat_q, NUM_PATTERNS);
                acnt_d = '0;
            end else begin
                acnt_d = acnt_q + CntW'(1);
            end
        end
        if (bus.ena) begin
            if (btn_press[BtnPause]) pause_d = ~pause_q;
            if (btn_press[BtnSpeed]) speed_d = ~speed_q;
            if (btn_press[BtnAuto]) begin
                auto_d = ~auto_q;
                acnt_d = '0;
            end
        end
        chg_d = (pat_d != pat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            speed_q <= 1'b0;
            pause_q <= 1'b0;
            auto_q  <= 1'b0;
            chg_q   <= 1'b0;
            acnt_q  <= '0;
        end else begin
            pat_q   <= pat_d;
            speed_q <= speed_d;
            pause_q <= pause_d;
            auto_q  <= auto_d;
            chg_q   <= chg_d;
            acnt_q  <= acnt_d;
        end
    end

    assign bus.pat_sel    = pat_q;
    assign bus.speed_sel  = speed_q;
    assign bus.pause      = pause_q;
    assign bus.auto_mode  = auto_q;
    assign bus.pat_change = chg_q;

endmodule

// File: tb/tb_led_ctrl_frontend.sv
// Self-checking bench for led_ctrl_frontend: vector table, corner sequences, random run.
module tb_led_ctrl_frontend;

    localparam int DC = 4;
    localparam int T  = 8;
    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_ctrl_frontend_if bus ();

    led_ctrl_frontend #(
        .DEBOUNCE_CYCLES (DC),
        .AUTO_CYCLE_TICKS(T),
        .NUM_PATTERNS    (NP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model. Bit order of button masks: 0 next, 1 prev, 2 pause, 3 speed, 4 auto.
    bit [15:0] hist [5];
    bit        mst  [5];
    bit        mpr  [5];
    int        m_pat, m_run;
    bit        m_speed, m_pause, m_auto, m_chg;

    function automatic void check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 5; b++) begin
            hist[b] = '0;
            mst[b]  = 1'b0;
            mpr[b]  = 1'b0;
        end
        m_pat = 0; m_run = 0; m_speed = 0; m_pause = 0; m_auto = 0; m_chg = 0;
    endfunction

    function automatic bit [4:0] cur_btns();
        return {bus.btn_auto, bus.btn_speed, bus.btn_pause, bus.btn_prev, bus.btn_next};
    endfunction

    // Advance the model across one clock edge using the inputs present before it.
    function automatic void model_step();
        bit [4:0] raw = cur_btns();
        bit en  = bus.ena;
        bit nx  = mpr[0] && en;
        bit pv  = mpr[1] && en;
        bit run = m_auto && !m_pause && en;
        int old = m_pat;
        if (nx && !pv) begin
            m_pat = (m_pat + 1) % NP; m_run = 0;
        end else if (pv && !nx) begin
            m_pat = (m_pat + NP - 1) % NP; m_run = 0;
        end else if (run) begin
            m_run++;
            if (m_run == T) begin
                m_pat = (m_pat + 1) % NP; m_run = 0;
            end
        end
        if (mpr[2] && en) m_pause = !m_pause;
        if (mpr[3] && en) m_speed = !m_speed;
        if (mpr[4] && en) begin
            m_auto = !m_auto; m_run = 0;
        end
        m_chg = (m_pat != old);
        // A level is accepted once the last DC synchronized samples all differ from it.
        for (int b = 0; b < 5; b++) begin
            bit all_diff = 1'b1;
            hist[b] = {hist[b][14:0], raw[b]};
            for (int j = 2; j < DC + 2; j++) if (hist[b][j] == mst[b]) all_diff = 1'b0;
            mpr[b] = 1'b0;
            if (all_diff) begin
                mst[b] = !mst[b];
                mpr[b] = mst[b];
            end
        end
    endfunction

    function automatic void check_outputs(string name);
        int act = {bus.pat_sel, bus.speed_sel, bus.pause, bus.auto_mode, bus.pat_change};
        int exp = {m_pat[2:0], m_speed, m_pause, m_auto, m_chg};
        check(name, act, exp);
    endfunction

    task automatic set_btns(input bit [4:0] m);
        bus.btn_next  = m[0];
        bus.btn_prev  = m[1];
        bus.btn_pause = m[2];
        bus.btn_speed = m[3];
        bus.btn_auto  = m[4];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs($sformatf("cycle@%0t", $time));
    endtask

    task automatic do_reset();
        bus.ena = 1'b1;
        set_btns(5'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit [4:0] m);
        set_btns(m);
        repeat (8) tick();
        set_btns(5'b0);
        repeat (10) tick();
    endtask

    task automatic wait_chg(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (bus.pat_change) break;
        end
    endtask

    typedef struct {
        bit       ena;
        bit [4:0] btns;
        int       pat;
        bit       speed;
        bit       pause;
        int       nchg;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n, p, cnt, seen, first;
        vecs[0]  = '{1, 5'b00001, 1, 0, 0, 1};
        vecs[1]  = '{1, 5'b00010, 0, 0, 0, 1};
        vecs[2]  = '{1, 5'b00010, 7, 0, 0, 1};
        vecs[3]  = '{1, 5'b00001, 0, 0, 0, 1};
        vecs[4]  = '{1, 5'b00001, 1, 0, 0, 1};
        vecs[5]  = '{1, 5'b00011, 1, 0, 0, 0};
        vecs[6]  = '{1, 5'b01000, 1, 1, 0, 0};
        vecs[7]  = '{1, 5'b00100, 1, 1, 1, 0};
        vecs[8]  = '{0, 5'b01000, 1, 1, 1, 0};
        vecs[9]  = '{0, 5'b00001, 1, 1, 1, 0};
        vecs[10] = '{1, 5'b01100, 1, 0, 0, 0};
        vecs[11] = '{1, 5'b01001, 2, 1, 0, 1};

        // Latency from the first sampling edge.
        do_reset();
        set_btns(5'b00001);
        first = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.pat_change) cnt++;
            if (first == 0 && bus.pat_sel == 3'd1) first = i;
        end
        check("latency_edge", first, 7);
        check("latency_pulses", cnt, 1);
        set_btns(5'b0);
        repeat (10) tick();

        // Bounce shorter than the debounce window, then a clean hold.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            set_btns(((i / 2) % 2 == 0) ? 5'b00001 : 5'b00000);
            tick();
            if (bus.pat_change) cnt++;
        end
        set_btns(5'b0);
        repeat (6) begin tick(); if (bus.pat_change) cnt++; end
        check("bounce_pulses", cnt, 0);
        check("bounce_pat", bus.pat_sel, 0);
        set_btns(5'b00001);
        repeat (10) tick();
        set_btns(5'b0);
        repeat (10) tick();
        check("bounce_then_hold", bus.pat_sel, 1);

        // Vector table.
        do_reset();
        foreach (vecs[v]) begin
            bus.ena = vecs[v].ena;
            set_btns(vecs[v].btns);
            cnt = 0;
            repeat (8) begin tick(); if (bus.pat_change) cnt++; end
            set_btns(5'b0);
            repeat (10) begin tick(); if (bus.pat_change) cnt++; end
            bus.ena = 1'b1;
            check($sformatf("vec%0d_state", v),
                  {bus.pat_sel, bus.speed_sel, bus.pause, bus.auto_mode},
                  {vecs[v].pat[2:0], vecs[v].speed, vecs[v].pause, 1'b0});
            check($sformatf("vec%0d_pulses", v), cnt, vecs[v].nchg);
        end

        // Auto mode period, wrap and pause.
        do_reset();
        press(5'b10000);
        check("auto_on", bus.auto_mode, 1);
        wait_chg(20, n);
        p = bus.pat_sel;
        wait_chg(20, n);
        check("auto_period", n, T);
        check("auto_inc", bus.pat_sel, (p + 1) % NP);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            p = bus.pat_sel;
            wait_chg(20, n);
            if (p == 7 && bus.pat_sel == 0) seen = 1;
        end
        check("auto_wrap", seen, 1);
        set_btns(5'b00100);
        repeat (8) tick();
        set_btns(5'b0);
        repeat (2) tick();
        check("pause_on", bus.pause, 1);
        p = bus.pat_sel; cnt = 0;
        repeat (30) begin tick(); if (bus.pat_change) cnt++; end
        check("pause_freeze_pulses", cnt, 0);
        check("pause_freeze_pat", bus.pat_sel, p);
        set_btns(5'b00100);
        n = 0;
        while (bus.pause && n < 12) begin tick(); n++; end
        check("pause_off", bus.pause, 0);
        set_btns(5'b0);
        wait_chg(T + 1, n);
        check("auto_resume", (bus.pat_change && n <= T) ? 1 : 0, 1);

        // Manual next landing on the auto terminal count.
        n = 0;
        while (m_run != 1 && n < 20) begin tick(); n++; end
        p = bus.pat_sel;
        set_btns(5'b00001);
        repeat (6) tick();
        check("manual_no_early_step", bus.pat_sel, p);
        tick();
        check("manual_single_step", bus.pat_sel, (p + 1) % NP);
        set_btns(5'b0);
        wait_chg(20, n);
        check("manual_then_period", n, T);

        // ena low drops presses; a button held across ena rising stays silent.
        do_reset();
        bus.ena = 1'b0;
        set_btns(5'b01001);
        repeat (10) tick();
        check("ena_low_speed", bus.speed_sel, 0);
        check("ena_low_pat", bus.pat_sel, 0);
        bus.ena = 1'b1;
        repeat (10) tick();
        check("ena_rise_held", {bus.pat_sel, bus.speed_sel}, 0);
        set_btns(5'b0);
        repeat (10) tick();

        // Asynchronous reset in the middle of auto mode.
        press(5'b10000);
        n = 0;
        while (bus.pat_sel != 3'd5 && n < 100) begin tick(); n++; end
        check("reach_pat5", bus.pat_sel, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset",
              {bus.pat_sel, bus.speed_sel, bus.pause, bus.auto_mode, bus.pat_change}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random button activity against the model.
        for (int i = 0; i < 2000; i++) begin
            bit [4:0] m = cur_btns();
            for (int b = 0; b < 5; b++) if ($urandom_range(0, 15) == 0) m[b] = ~m[b];
            set_btns(m);
            if ($urandom_range(0, 63) == 0) bus.ena = ~bus.ena;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
